// File: rtl/vga_sync_monitor_if.sv
// Sync pair and measurement bundle between a VGA sync source and the timing monitor.
interface vga_sync_monitor_if;
  logic        hsync_n;
  logic        vsync_n;
  logic [10:0] h_total;
  logic [10:0] h_sync_w;
  logic [10:0] v_total;
  logic [10:0] v_sync_w;
  logic [7:0]  frame_cnt;
  logic        locked;
  logic [1:0]  mode_id;

  // Source side: drives the syncs, may observe the measurements.
  modport master (
    output hsync_n, vsync_n,
    input  h_total, h_sync_w, v_total, v_sync_w, frame_cnt, locked, mode_id
  );

  // Monitor side: observes the syncs, produces the measurements.
  modport slave (
    input  hsync_n, vsync_n,
    output h_total, h_sync_w, v_total, v_sync_w, frame_cnt, locked, mode_id
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: passive measurement of VGA hsync/vsync timing in clk cycles,
// with frame counting, a two-frame stability lock and known-mode recognition.
module vga_sync_monitor #(
  parameter int unsigned MODE0_H = 800,
  parameter int unsigned MODE0_V = 525,
  parameter int unsigned MODE1_H = 952,
  parameter int unsigned MODE1_V = 932
) (
  input  logic              clk,
  input  logic              reset_n,
  vga_sync_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECK    = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

  localparam logic [10:0] CNT_MAX = 11'd2047;

  // Increment that sticks at the counter ceiling instead of wrapping.
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

  // Map a locked (h_total, v_total) pair to its mode code.
  function automatic logic [1:0] classify(input logic [10:0] h, input logic [10:0] v);
    if (h == 11'(MODE0_H) && v == 11'(MODE0_V)) return 2'd1;
    else if (h == 11'(MODE1_H) && v == 11'(MODE1_V)) return 2'd2;
    else return 2'd0;
  endfunction

  // Bit 0 = first sync flop, bit 1 = second sync flop, bit 2 = edge history.
  logic [2:0]  hs_q, hs_d, vs_q, vs_d;
  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic [10:0] hcnt_q, hcnt_d, hlow_q, hlow_d;
  logic [10:0] vcnt_q, vcnt_d, vlow_q, vlow_d, vlow_inc;
  logic [10:0] h_total_q, h_total_d, h_sync_w_q, h_sync_w_d;
  logic [10:0] v_total_q, v_total_d, v_sync_w_q, v_sync_w_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        v_seen_q, v_seen_d;
  logic        step_q, step_d;
  lock_state_e state_q, state_d;
  logic [10:0] ref_h_q, ref_h_d, ref_v_q, ref_v_d;
  logic        locked_q, locked_d;
  logic [1:0]  mode_q, mode_d;
  logic        timeout, pair_match;

  // Synchroniser shift and edge detection on the settled history pair.
  always_comb begin
    hs_d    = {hs_q[1:0], mon.hsync_n};
    vs_d    = {vs_q[1:0], mon.vsync_n};
    hs_fall = hs_q[2] & ~hs_q[1];
    hs_rise = ~hs_q[2] & hs_q[1];
    vs_fall = vs_q[2] & ~vs_q[1];
    vs_rise = ~vs_q[2] & vs_q[1];
  end

  // Line period and hsync pulse width measurement.
  always_comb begin
    hcnt_d     = sat_inc(hcnt_q);
    h_total_d  = h_total_q;
    hlow_d     = hlow_q;
    h_sync_w_d = h_sync_w_q;
    if (hs_fall) begin
      h_total_d = sat_inc(hcnt_q);
      hcnt_d    = 11'd0;
    end else begin
      hcnt_d = sat_inc(hcnt_q);
    end
    if (hs_rise) begin
      h_sync_w_d = sat_inc(hlow_q);
      hlow_d     = 11'd0;
    end else if (!hs_q[2]) begin
      hlow_d = sat_inc(hlow_q);
    end else begin
      hlow_d = hlow_q;
    end
  end

  // Lines per frame, vsync width and frame count; the first vsync edge after
  // reset only arms the line counter.
  always_comb begin
    vcnt_d      = hs_fall ? sat_inc(vcnt_q) : vcnt_q;
    v_total_d   = v_total_q;
    frame_cnt_d = frame_cnt_q;
    v_seen_d    = v_seen_q;
    step_d      = 1'b0;
    vlow_inc    = (!vs_q[2] && hs_fall) ? sat_inc(vlow_q) : vlow_q;
    vlow_d      = vlow_inc;
    v_sync_w_d  = v_sync_w_q;
    if (vs_fall) begin
      // A coincident hsync edge opens the new frame, so it is counted there.
      vcnt_d      = hs_fall ? 11'd1 : 11'd0;
      frame_cnt_d = frame_cnt_q + 8'd1;
      v_seen_d    = 1'b1;
      if (v_seen_q) begin
        v_total_d = vcnt_q;
        step_d    = 1'b1;
      end else begin
        v_total_d = v_total_q;
        step_d    = 1'b0;
      end
    end else begin
      vcnt_d = hs_fall ? sat_inc(vcnt_q) : vcnt_q;
    end
    if (vs_rise) begin
      v_sync_w_d = vlow_inc;
      vlow_d     = 11'd0;
    end else begin
      vlow_d = vlow_inc;
    end
  end

  // Lock state machine, stepped the cycle after a v_total latch so it sees
  // the freshly latched pair; a saturated counter forces it back to UNLOCKED.
  always_comb begin
    state_d    = state_q;
    ref_h_d    = ref_h_q;
    ref_v_d    = ref_v_q;
    mode_d     = mode_q;
    timeout    = (hcnt_q == CNT_MAX) || (vcnt_q == CNT_MAX);
    pair_match = (h_total_q == ref_h_q) && (v_total_q == ref_v_q);
    if (timeout) begin
      state_d = ST_UNLOCKED;
    end else if (step_q) begin
      case (state_q)
        ST_UNLOCKED: begin
          state_d = ST_CHECK;
          ref_h_d = h_total_q;
          ref_v_d = v_total_q;
        end
        ST_CHECK, ST_LOCKED: begin
          if (pair_match) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_CHECK;
            ref_h_d = h_total_q;
            ref_v_d = v_total_q;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end else begin
      state_d = state_q;
    end
    locked_d = (state_d == ST_LOCKED);
    if (state_d != ST_LOCKED) begin
      mode_d = 2'd0;
    end else if (step_q) begin
      mode_d = classify(h_total_q, v_total_q);
    end else begin
      mode_d = mode_q;
    end
  end

  // State registers; sync flops idle high so reset release creates no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q        <= 3'b111;
      vs_q        <= 3'b111;
      hcnt_q      <= 11'd0;
      hlow_q      <= 11'd0;
      vcnt_q      <= 11'd0;
      vlow_q      <= 11'd0;
      h_total_q   <= 11'd0;
      h_sync_w_q  <= 11'd0;
      v_total_q   <= 11'd0;
      v_sync_w_q  <= 11'd0;
      frame_cnt_q <= 8'd0;
      v_seen_q    <= 1'b0;
      step_q      <= 1'b0;
      state_q     <= ST_UNLOCKED;
      ref_h_q     <= 11'd0;
      ref_v_q     <= 11'd0;
      locked_q    <= 1'b0;
      mode_q      <= 2'd0;
    end else begin
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      hcnt_q      <= hcnt_d;
      hlow_q      <= hlow_d;
      vcnt_q      <= vcnt_d;
      vlow_q      <= vlow_d;
      h_total_q   <= h_total_d;
      h_sync_w_q  <= h_sync_w_d;
      v_total_q   <= v_total_d;
      v_sync_w_q  <= v_sync_w_d;
      frame_cnt_q <= frame_cnt_d;
      v_seen_q    <= v_seen_d;
      step_q      <= step_d;
      state_q     <= state_d;
      ref_h_q     <= ref_h_d;
      ref_v_q     <= ref_v_d;
      locked_q    <= locked_d;
      mode_q      <= mode_d;
    end
  end

  assign mon.h_total   = h_total_q;
  assign mon.h_sync_w  = h_sync_w_q;
  assign mon.v_total   = v_total_q;
  assign mon.v_sync_w  = v_sync_w_q;
  assign mon.frame_cnt = frame_cnt_q;
  assign mon.locked    = locked_q;
  assign mon.mode_id   = mode_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor: drives small rasters, pushes the measurement each
// finished frame should produce, and compares it when the next vsync edge latches.
module tb_vga_sync_monitor;
  localparam int M0H = 40;
  localparam int M0V = 10;
  localparam int M1H = 48;
  localparam int M1V = 12;

  typedef struct {
    logic [10:0] ht;
    logic [10:0] hw;
    logic [10:0] vt;
    logic [10:0] vw;
    logic [7:0]  fc;
    logic        lk;
    logic [1:0]  md;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  vga_sync_monitor_if vif();

  vga_sync_monitor #(.MODE0_H(M0H), .MODE0_V(M0V), .MODE1_H(M1H), .MODE1_V(M1V)) dut (
    .clk(clk), .reset_n(reset_n), .mon(vif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];
  int m_state = 0;
  logic [10:0] m_ref_h = 11'd0;
  logic [10:0] m_ref_v = 11'd0;
  logic [7:0] m_fc = 8'd0;

  // Drive one frame; vsync falls with the line-0 hsync edge. Early in line 0
  // the previous frame's expectation is popped and compared.
  task automatic drive_frame(input int h, input int hw, input int v, input int vw);
    exp_t e;
    exp_t n;
    m_fc = m_fc + 8'd1;
    for (int ln = 0; ln < v; ln++) begin
      for (int c = 0; c < h; c++) begin
        vif.hsync_n = (c < hw) ? 1'b0 : 1'b1;
        vif.vsync_n = (ln < vw) ? 1'b0 : 1'b1;
        if (ln == 0 && c == 5 && sb_q.size() > 0) begin
          @(negedge clk);
          e = sb_q.pop_front();
          n_checks++; if (vif.h_total !== e.ht) begin n_errors++; $display("FAIL frame h_total got %0d exp %0d", vif.h_total, e.ht); end
          n_checks++; if (vif.h_sync_w !== e.hw) begin n_errors++; $display("FAIL frame h_sync_w got %0d exp %0d", vif.h_sync_w, e.hw); end
          n_checks++; if (vif.v_total !== e.vt) begin n_errors++; $display("FAIL frame v_total got %0d exp %0d", vif.v_total, e.vt); end
          n_checks++; if (vif.v_sync_w !== e.vw) begin n_errors++; $display("FAIL frame v_sync_w got %0d exp %0d", vif.v_sync_w, e.vw); end
          n_checks++; if (vif.frame_cnt !== e.fc) begin n_errors++; $display("FAIL frame frame_cnt got %0d exp %0d", vif.frame_cnt, e.fc); end
          n_checks++; if (vif.locked !== e.lk) begin n_errors++; $display("FAIL frame locked got %0b exp %0b", vif.locked, e.lk); end
          n_checks++; if (vif.mode_id !== e.md) begin n_errors++; $display("FAIL frame mode_id got %0d exp %0d", vif.mode_id, e.md); end
        end
        @(posedge clk); #1;
      end
    end
    // Expected result of the latch at the next frame's vsync edge.
    if (m_state != 0 && 11'(h) == m_ref_h && 11'(v) == m_ref_v) m_state = 2;
    else m_state = 1;
    m_ref_h = 11'(h);
    m_ref_v = 11'(v);
    n.ht = 11'(h);
    n.hw = 11'(hw);
    n.vt = 11'(v);
    n.vw = 11'(vw);
    n.fc = m_fc + 8'd1;
    n.lk = (m_state == 2);
    if (m_state == 2 && h == M0H && v == M0V) n.md = 2'd1;
    else if (m_state == 2 && h == M1H && v == M1V) n.md = 2'd2;
    else n.md = 2'd0;
    sb_q.push_back(n);
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_state = 0;
    m_ref_h = 11'd0;
    m_ref_v = 11'd0;
    m_fc = 8'd0;
  endtask

  task automatic test_reset();
    vif.hsync_n = 1'b1;
    vif.vsync_n = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (vif.h_total !== 11'd0) begin n_errors++; $display("FAIL reset h_total got %0d exp 0", vif.h_total); end
    n_checks++; if (vif.v_total !== 11'd0) begin n_errors++; $display("FAIL reset v_total got %0d exp 0", vif.v_total); end
    n_checks++; if (vif.frame_cnt !== 8'd0) begin n_errors++; $display("FAIL reset frame_cnt got %0d exp 0", vif.frame_cnt); end
    n_checks++; if (vif.locked !== 1'b0) begin n_errors++; $display("FAIL reset locked got %0b exp 0", vif.locked); end
    n_checks++; if (vif.mode_id !== 2'd0) begin n_errors++; $display("FAIL reset mode_id got %0d exp 0", vif.mode_id); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    model_reset();
  endtask

  task automatic test_mode0();
    repeat (3) drive_frame(M0H, 6, M0V, 2);
  endtask

  task automatic test_bad_frame();
    drive_frame(M0H, 6, M0V - 1, 2);
    repeat (3) drive_frame(M0H, 6, M0V, 2);
  endtask

  task automatic test_mode1();
    repeat (3) drive_frame(M1H, 5, M1V, 3);
  endtask

  task automatic test_timeout();
    sb_q.delete();
    vif.hsync_n = 1'b1;
    vif.vsync_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        @(negedge clk);
        n_checks++; if (vif.locked !== 1'b1) begin n_errors++; $display("FAIL pre_timeout locked got %0b exp 1", vif.locked); end
        n_checks++; if (vif.mode_id !== 2'd2) begin n_errors++; $display("FAIL pre_timeout mode_id got %0d exp 2", vif.mode_id); end
      end
      if (c == 2200) begin
        @(negedge clk);
        n_checks++; if (vif.locked !== 1'b0) begin n_errors++; $display("FAIL timeout locked got %0b exp 0", vif.locked); end
        n_checks++; if (vif.mode_id !== 2'd0) begin n_errors++; $display("FAIL timeout mode_id got %0d exp 0", vif.mode_id); end
        n_checks++; if (vif.h_total !== 11'(M1H)) begin n_errors++; $display("FAIL timeout h_total got %0d exp %0d", vif.h_total, M1H); end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++; if (vif.h_total !== 11'(M1H)) begin n_errors++; $display("FAIL hold_end h_total got %0d exp %0d", vif.h_total, M1H); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2 * M0H; c++) begin
      vif.hsync_n = ((c % M0H) < 6) ? 1'b0 : 1'b1;
      vif.vsync_n = 1'b1;
      @(posedge clk); #1;
    end
    vif.hsync_n = 1'b0;
    reset_n = 1'b0;
    #2;
    n_checks++; if (vif.h_total !== 11'd0) begin n_errors++; $display("FAIL mid_reset h_total got %0d exp 0", vif.h_total); end
    n_checks++; if (vif.h_sync_w !== 11'd0) begin n_errors++; $display("FAIL mid_reset h_sync_w got %0d exp 0", vif.h_sync_w); end
    n_checks++; if (vif.v_total !== 11'd0) begin n_errors++; $display("FAIL mid_reset v_total got %0d exp 0", vif.v_total); end
    n_checks++; if (vif.v_sync_w !== 11'd0) begin n_errors++; $display("FAIL mid_reset v_sync_w got %0d exp 0", vif.v_sync_w); end
    n_checks++; if (vif.frame_cnt !== 8'd0) begin n_errors++; $display("FAIL mid_reset frame_cnt got %0d exp 0", vif.frame_cnt); end
    n_checks++; if (vif.locked !== 1'b0) begin n_errors++; $display("FAIL mid_reset locked got %0b exp 0", vif.locked); end
    n_checks++; if (vif.mode_id !== 2'd0) begin n_errors++; $display("FAIL mid_reset mode_id got %0d exp 0", vif.mode_id); end
    repeat (3) begin @(posedge clk); #1; end
    vif.hsync_n = 1'b1;
    vif.vsync_n = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    @(negedge clk);
    n_checks++; if (vif.h_total !== 11'd0) begin n_errors++; $display("FAIL release h_total got %0d exp 0", vif.h_total); end
    n_checks++; if (vif.h_sync_w !== 11'd0) begin n_errors++; $display("FAIL release h_sync_w got %0d exp 0", vif.h_sync_w); end
    n_checks++; if (vif.v_sync_w !== 11'd0) begin n_errors++; $display("FAIL release v_sync_w got %0d exp 0", vif.v_sync_w); end
    n_checks++; if (vif.frame_cnt !== 8'd0) begin n_errors++; $display("FAIL release frame_cnt got %0d exp 0", vif.frame_cnt); end
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_frame_wrap();
    repeat (256) drive_frame(10, 3, 4, 1);
    @(negedge clk);
    n_checks++; if (vif.frame_cnt !== 8'd0) begin n_errors++; $display("FAIL wrap frame_cnt got %0d exp 0", vif.frame_cnt); end
  endtask

  // Whole-run time limit so the bench always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Scenario sequence.
  initial begin
    test_reset();
    test_mode0();
    test_bad_frame();
    test_mode1();
    test_timeout();
    test_reset_mid();
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
